// File: rtl/sym_pkg.sv
// sym_pattern_tx shared types: 2-bit symbol and FSM encodings.
// Optional per-pass checksum symbol: define SYM_TX_CHKSUM_EN.
package sym_pkg;
  typedef logic [1:0] sym_t;

  localparam sym_t SYM_IDLE = 2'b00;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;
endpackage

// File: rtl/sym_pattern_tx_if.sv
// Host/detector bundle for sym_pattern_tx.
// master = host/stimulus side, slave = transmitter.
interface sym_pattern_tx_if #(
  parameter int REP_W = 4
);
  logic              wr_en;
  sym_pkg::sym_t     wr_sym;
  logic              wr_rdy;
  logic              clr;
  logic              start;
  logic [REP_W-1:0]  rep;
  logic              abort;
  logic              x1;
  logic              x0;
  logic              sym_vld;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_sym, clr, start,
    output rep, abort,
    input  wr_rdy, x1, x0, sym_vld,
    input  busy, done
  );

  modport slave (
    input  wr_en, wr_sym, clr, start,
    input  rep, abort,
    output wr_rdy, x1, x0, sym_vld,
    output busy, done
  );
endinterface

// File: rtl/sym_buf.sv
// Pattern buffer: DEPTH x 2-bit register file with fill count.
// Only the count is reset; contents survive reset and clr.
module sym_buf
  import sym_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          r,
  input  logic          we,
  input  sym_t          wsym,
  input  logic          clr,
  input  logic [CW-1:0] ridx,
  output sym_t          rsym,
  output logic [CW:0]   cnt
);
  sym_t        mem_q [DEPTH];
  logic [CW:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (we) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) cnt_q <= '0;
    else   cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[cnt_q[CW-1:0]] <= wsym;
  end

  assign rsym = mem_q[ridx];
  assign cnt  = cnt_q;
endmodule

// File: rtl/sym_pattern_tx.sv
// Replays a stored symbol pattern onto x1/x0 with idle gaps.
// SYM_TX_CHKSUM_EN adds an XOR checksum symbol after each pass.
module sym_pattern_tx
  import sym_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 3,
  parameter int GAP   = 2,
  parameter int REP_W = 4
) (
  input  logic clk,
  input  logic r,
  sym_pattern_tx_if.slave bus
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW:0]   FULL  = (CW+1)'(DEPTH);
  localparam logic [GW-1:0] GLAST = GW'(GAP > 0 ? GAP - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  sym_t             x_q, x_d;
  logic             vld_q, busy_q;
  logic             done_q, done_d;
  logic [CW:0]      cnt;
  sym_t             rsym;
  logic             idle, rdy, we, clr_b;
  logic             last, pass_end;
`ifdef SYM_TX_CHKSUM_EN
  logic             ck_q, ck_d;
  sym_t             acc_q, acc_d;
`endif

  assign idle  = state_q == ST_IDLE;
  assign rdy   = idle && (cnt < FULL) &&
                 !bus.start && !bus.clr && !r;
  assign we    = bus.wr_en && rdy;
  assign clr_b = idle && bus.clr;
  assign last  = {1'b0, idx_q} == (cnt - 1'b1);

  sym_buf #(.DEPTH(DEPTH), .CW(CW)) u_buf (
    .clk  (clk),
    .r    (r),
    .we   (we),
    .wsym (bus.wr_sym),
    .clr  (clr_b),
    .ridx (idx_d),
    .rsym (rsym),
    .cnt  (cnt)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    gcnt_d   = gcnt_q;
    done_d   = 1'b0;
    pass_end = 1'b0;
    x_d      = SYM_IDLE;
`ifdef SYM_TX_CHKSUM_EN
    ck_d     = ck_q;
    acc_d    = acc_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.clr && bus.start && cnt != '0) begin
          state_d = ST_SEND;
          idx_d   = '0;
          pass_d  = bus.rep;
`ifdef SYM_TX_CHKSUM_EN
          ck_d    = 1'b0;
`endif
        end
      end
      ST_SEND: begin
        if (bus.abort) state_d = ST_IDLE;
        else begin
`ifdef SYM_TX_CHKSUM_EN
          if (ck_q)      pass_end = 1'b1;
          else if (last) ck_d = 1'b1;
          else           idx_d = idx_q + 1'b1;
`else
          if (last) pass_end = 1'b1;
          else      idx_d = idx_q + 1'b1;
`endif
        end
        if (pass_end) begin
          if (pass_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            pass_d  = pass_q - 1'b1;
            idx_d   = '0;
            gcnt_d  = '0;
            state_d = (GAP == 0) ? ST_SEND : ST_GAP;
`ifdef SYM_TX_CHKSUM_EN
            ck_d    = 1'b0;
`endif
          end
        end
      end
      ST_GAP: begin
        if (bus.abort) state_d = ST_IDLE;
        else if (gcnt_q == GLAST) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end else gcnt_d = gcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // output is loaded from the next state so it lines up with state_q
    if (state_d == ST_SEND) begin
`ifdef SYM_TX_CHKSUM_EN
      if (ck_d) x_d = acc_q;
      else begin
        x_d   = rsym;
        acc_d = ((idx_d == '0) ? SYM_IDLE : acc_q) ^ rsym;
      end
`else
      x_d = rsym;
`endif
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pass_q  <= '0;
      gcnt_q  <= '0;
      x_q     <= SYM_IDLE;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      gcnt_q  <= gcnt_d;
      x_q     <= x_d;
      vld_q   <= state_d == ST_SEND;
      busy_q  <= state_d != ST_IDLE;
      done_q  <= done_d;
    end
  end

`ifdef SYM_TX_CHKSUM_EN
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      ck_q  <= 1'b0;
      acc_q <= SYM_IDLE;
    end else begin
      ck_q  <= ck_d;
      acc_q <= acc_d;
    end
  end
`endif

  assign bus.wr_rdy  = rdy;
  assign bus.x1      = x_q[1];
  assign bus.x0      = x_q[0];
  assign bus.sym_vld = vld_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_sym_pattern_tx.sv
// Bench for sym_pattern_tx: directed scenarios plus random traffic
// against a queue-based model of the expected output stream.
module tb_sym_pattern_tx;
  import sym_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 3;
  localparam int GAP   = 2;
  localparam int REP_W = 4;
`ifdef SYM_TX_CHKSUM_EN
  localparam int CKX = 1;
`else
  localparam int CKX = 0;
`endif

  logic clk = 1'b0;
  logic r;
  always #5 clk = ~clk;

  sym_pattern_tx_if #(.REP_W(REP_W)) bus ();

  sym_pattern_tx #(
    .DEPTH(DEPTH), .CW(CW), .GAP(GAP), .REP_W(REP_W)
  ) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model: {x1,x0,sym_vld,busy,done} per cycle
  sym_t       pat[$];
  logic [4:0] expq[$];
  logic [4:0] cur;
  int nb, nv, nd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [4:0] obs();
    return {bus.x1, bus.x0, bus.sym_vld, bus.busy, bus.done};
  endfunction

  task automatic load_run(input int rp);
    sym_t ck;
    expq.delete();
    for (int p = 0; p <= rp; p++) begin
      ck = '0;
      foreach (pat[i]) begin
        expq.push_back({pat[i], 3'b110});
        ck ^= pat[i];
      end
      if (CKX == 1) expq.push_back({ck, 3'b110});
      if (p < rp) repeat (GAP) expq.push_back(5'b00010);
    end
    expq.push_back(5'b00001);
  endtask

  task automatic step(input logic we, input sym_t ws,
                      input logic cl, input logic st,
                      input logic [REP_W-1:0] rp,
                      input logic ab);
    logic idle, rdy;
    bus.wr_en  = we;
    bus.wr_sym = ws;
    bus.clr    = cl;
    bus.start  = st;
    bus.rep    = rp;
    bus.abort  = ab;
    idle = !cur[1];
    rdy  = idle && pat.size() < DEPTH && !st && !cl;
    #1;
    chk("wr_rdy", 32'(bus.wr_rdy), 32'(rdy));
    if (idle) begin
      if (cl) pat.delete();
      else if (st) begin
        if (pat.size() > 0) load_run(int'(rp));
      end else if (we && rdy) pat.push_back(ws);
    end else if (ab) expq.delete();
    cur = (expq.size() > 0) ? expq.pop_front() : 5'b0;
    @(posedge clk);
    #1;
    chk("out", 32'(obs()), 32'(cur));
    nb += int'(bus.busy);
    nv += int'(bus.sym_vld);
    nd += int'(bus.done);
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input sym_t s);
    step(1'b1, s, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic clear();
    step(1'b0, 2'b00, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic go(input logic [REP_W-1:0] rp);
    step(1'b0, 2'b00, 1'b0, 1'b1, rp, 1'b0);
  endtask

  task automatic async_reset();
    #2 r = 1'b1;
    #1;
    chk("rst_out", 32'(obs()), 32'd0);
    chk("rst_rdy", 32'(bus.wr_rdy), 32'd0);
    @(posedge clk);
    #1 r = 1'b0;
    pat.delete();
    expq.delete();
    cur = '0;
  endtask

  initial begin
    int k;
    r = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sym = '0; bus.clr = 1'b0;
    bus.start = 1'b0; bus.rep = '0;   bus.abort = 1'b0;
    cur = '0;
    nb = 0; nv = 0; nd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 32'(obs()), 32'd0);
    chk("reset_rdy", 32'(bus.wr_rdy), 32'd0);
    r = 1'b0;

    // 01,11,01 twice with a gap
    wr(2'b01); wr(2'b11); wr(2'b01);
    nb = 0; nv = 0; nd = 0;
    go(4'd1);
    idle_n(13);
    chk("busy_cycles", 32'(nb), 32'(3 * 2 + GAP + 2 * CKX));
    chk("vld_cycles", 32'(nv), 32'(6 + 2 * CKX));
    chk("done_pulses", 32'(nd), 32'd1);

    // replay the same pattern, single pass
    go(4'd0);
    idle_n(6);

    // overflow: nine writes into an eight-deep buffer
    clear();
    for (int i = 0; i < 9; i++) wr(sym_t'($urandom_range(0, 3)));
    nv = 0;
    go(4'd0);
    idle_n(12);
    chk("full_syms", 32'(nv), 32'(8 + CKX));

    // start with a write in the same cycle; start when empty
    clear();
    wr(2'b10); wr(2'b11);
    step(1'b1, 2'b01, 1'b0, 1'b1, 4'd0, 1'b0);
    idle_n(5);
    clear();
    nb = 0;
    go(4'd2);
    idle_n(2);
    chk("empty_start", 32'(nb), 32'd0);

    // abort on second symbol of the first pass, then restart
    wr(2'b01); wr(2'b10); wr(2'b11);
    go(4'd3);
    idle_n(1);
    nd = 0;
    step(1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b1);
    idle_n(2);
    chk("abort_done", 32'(nd), 32'd0);
    go(4'd0);
    idle_n(6);

    // asynchronous reset mid-pass
    go(4'd2);
    idle_n(2);
    nd = 0;
    async_reset();
    go(4'd1);
    idle_n(2);
    chk("rst_done", 32'(nd), 32'd0);

    for (int it = 0; it < 1500; it++) begin
      k = int'($urandom_range(0, 99));
      if (!cur[1]) begin
        if (k < 45)
          wr(sym_t'($urandom_range(0, 3)));
        else if (k < 50)
          clear();
        else if (k < 65)
          step(1'($urandom_range(0, 1)),
               sym_t'($urandom_range(0, 3)), 1'b0, 1'b1,
               REP_W'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
        else if (k < 68)
          step(1'b1, sym_t'($urandom_range(0, 3)), 1'b1,
               1'($urandom_range(0, 1)), '0, 1'b0);
        else
          step(1'b0, 2'b00, 1'b0, 1'b0, '0,
               1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 1)),
             sym_t'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             REP_W'($urandom_range(0, 3)), k < 3);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
